// File: rtl/display_272p_pkg.sv
// Timing constants and shared types for the 480x272 RGB LCD Pmod timing generator.
package display_272p_pkg;

    // Coordinate width wide enough for the 525-pixel line and 286-line frame
    localparam int LCD_CORDW  = 10;

    // Horizontal timing, in pixels (active area first)
    localparam int LCD_H_RES  = 480;
    localparam int LCD_H_FP   = 2;
    localparam int LCD_H_SYNC = 41;
    localparam int LCD_H_BP   = 2;

    // Vertical timing, in lines (active area first)
    localparam int LCD_V_RES  = 272;
    localparam int LCD_V_FP   = 2;
    localparam int LCD_V_SYNC = 10;
    localparam int LCD_V_BP   = 2;

    // Both syncs are active-low on this panel
    localparam logic LCD_H_POL = 1'b0;
    localparam logic LCD_V_POL = 1'b0;

    // Derived totals: 525 x 286 = 150150 pixel clocks per frame
    localparam int H_TOTAL = LCD_H_RES + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;
    localparam int V_TOTAL = LCD_V_RES + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;

    typedef logic [LCD_CORDW-1:0] coord_t;

endpackage

// File: rtl/sig_delay.sv
// N-stage shift register with a loadable reset value; N=0 is a plain wire.
module sig_delay #(
    parameter int W = 1,
    parameter int N = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] rst_val_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (N == 0) begin : g_pass
        // Clock, reset and reset value have no role without stages
        logic unused_inputs;
        assign unused_inputs = ^{clk_i, rst_i, rst_val_i};
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] stage_q [N];

        // Shift the bundle one stage per clock; reset loads the idle value everywhere
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < N; i++) stage_q[i] <= rst_val_i;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[N-1];
    end

endmodule

// File: rtl/display_timings_272p.sv
// Pixel-clock timing generator for the 480x272 LCD: coordinates, syncs, data
// enable, line/frame strobes and a wrapping frame counter. Syncs, de and the
// strobes are decoded from the next-count values so they register together
// with the sx/sy they describe; an optional delay realigns hsync/vsync/de.
module display_timings_272p
    import display_272p_pkg::*;
#(
    parameter int   CORDW  = LCD_CORDW,
    parameter int   H_RES  = LCD_H_RES,
    parameter int   H_FP   = LCD_H_FP,
    parameter int   H_SYNC = LCD_H_SYNC,
    parameter int   H_BP   = LCD_H_BP,
    parameter int   V_RES  = LCD_V_RES,
    parameter int   V_FP   = LCD_V_FP,
    parameter int   V_SYNC = LCD_V_SYNC,
    parameter int   V_BP   = LCD_V_BP,
    parameter logic H_POL  = LCD_H_POL,
    parameter logic V_POL  = LCD_V_POL,
    parameter int   PIPE   = 0,
    parameter int   FCW    = 8
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic [FCW-1:0]   frame_cnt
);

    localparam int HT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int VT = V_RES + V_FP + V_SYNC + V_BP;

    // Boundary constants, all compared unsigned at CORDW bits
    localparam logic [CORDW-1:0] H_LAST = CORDW'(HT - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(VT - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_STA = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_STA = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

    // Refuse to elaborate if any boundary would be truncated
    if (HT > (2 ** CORDW)) begin : g_bad_h
        $error("horizontal total does not fit in CORDW bits");
    end
    if (VT > (2 ** CORDW)) begin : g_bad_v
        $error("vertical total does not fit in CORDW bits");
    end
    if (PIPE < 0 || PIPE > 3) begin : g_bad_pipe
        $error("PIPE must be in 0..3");
    end

    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic [FCW-1:0]   fcnt_q;

    // Next counter values and the signals decoded from them
    always_comb begin
        sx_d = sx_q + 1'b1;
        sy_d = sy_q;
        if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
        end
        hs_d    = (sx_d >= HS_STA && sx_d <= HS_END) ? H_POL : ~H_POL;
        // Depends on sy only, so it can only change when sx wraps to 0
        vs_d    = (sy_d >= VS_STA && sy_d <= VS_END) ? V_POL : ~V_POL;
        de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
        line_d  = (sx_d == '0);
        frame_d = (sx_d == '0) && (sy_d == V_ACT);
    end

    // Register counters, decodes and the frame counter; reset parks at the last pixel
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sx_q    <= H_LAST;
            sy_q    <= V_LAST;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            if (frame_d) fcnt_q <= fcnt_q + 1'b1;
        end
    end

    logic [2:0] sync_idle;
    logic [2:0] sync_dly;
    assign sync_idle = {~H_POL, ~V_POL, 1'b0};

    sig_delay #(
        .W (3),
        .N (PIPE)
    ) u_sync_dly (
        .clk_i     (clk_pix),
        .rst_i     (rst_pix),
        .rst_val_i (sync_idle),
        .d_i       ({hs_q, vs_q, de_q}),
        .q_o       (sync_dly)
    );

    assign sx        = sx_q;
    assign sy        = sy_q;
    assign hsync     = sync_dly[2];
    assign vsync     = sync_dly[1];
    assign de        = sync_dly[0];
    assign line      = line_q;
    assign frame     = frame_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: doc/display_timings_272p.md
# display_timings_272p

Display timing generator for the 480×272 RGB LCD Pmod. It runs in the pixel-clock domain and produces the screen coordinates `sx`/`sy` plus the sync and data-enable signals. It also emits line and frame strobes and a frame counter, so downstream drawing/animation logic needs no local counters. It sits directly upstream of the drawing/paint stage and the registered LCD output stage. An optional delay pipeline realigns `hsync`/`vsync`/`de` with the paint stage's latency.

## Interface
- `CORDW`, 10: coordinate width in bits.
- `H_RES`, 480: active pixels per line.
- `H_FP`, 2: horizontal front porch, in pixels.
- `H_SYNC`, 41: horizontal sync width, in pixels.
- `H_BP`, 2: horizontal back porch, in pixels.
- `V_RES`, 272: active lines.
- `V_FP`, 2: vertical front porch, in lines.
- `V_SYNC`, 10: vertical sync width, in lines.
- `V_BP`, 2: vertical back porch, in lines.
- `H_POL`, 0: active level of `hsync`.
- `V_POL`, 0: active level of `vsync`.
- `PIPE`, 0: extra register stages, 0..3, applied to `hsync`/`vsync`/`de` only.
- `FCW`, 8: frame counter width.
- `clk_pix` input 1: pixel clock; all logic in this single domain.
- `rst_pix` input 1: reset, asynchronous, active-high.
- `sx` output CORDW: horizontal position, 0..H_TOTAL-1.
- `sy` output CORDW: vertical position, 0..V_TOTAL-1.
- `hsync` output 1: horizontal sync, level set by `H_POL`.
- `vsync` output 1: vertical sync, level set by `V_POL`.
- `de` output 1: high in the active area.
- `line` output 1: one-cycle strobe at `sx==0`, every line.
- `frame` output 1: one-cycle strobe at `sx==0 && sy==V_RES` (start of vertical blanking).
- `frame_cnt` output FCW: frames completed, wraps.

## Operation
- H_TOTAL = H_RES+H_FP+H_SYNC+H_BP = 525.
- V_TOTAL = V_RES+V_FP+V_SYNC+V_BP = 286.
- Frame period = 150150 cycles (60 Hz at 9.009 MHz).
- Active area comes first: `sx` 0..H_RES-1, then front porch, sync, back porch; same order vertically.
- `sx` increments every cycle. At H_TOTAL-1 it wraps to 0 and `sy` increments; `sy` wraps to 0 after V_TOTAL-1.
- hsync is active for H_RES+H_FP ≤ sx ≤ H_RES+H_FP+H_SYNC-1 (482..522).
- vsync is active for V_RES+V_FP ≤ sy ≤ V_RES+V_FP+V_SYNC-1 (274..283). vsync is a whole-line signal: it changes only at `sx==0`.
- `de` = (sx < H_RES) && (sy < V_RES).
- All outputs are registered. Syncs, `de` and both strobes are decoded from the next-count values, so with `PIPE=0` they are cycle-aligned with the `sx`/`sy` they describe.
- `frame_cnt` increments in the same cycle `frame` is high; at 2^FCW-1 it wraps to 0.
- Arithmetic: all comparisons are unsigned at CORDW bits. Every boundary constant must fit in CORDW; this is checked by elaboration-time assertion.

## Timing
- Reset values:
  - `sx`=H_TOTAL-1, `sy`=V_TOTAL-1.
  - `hsync`=!H_POL, `vsync`=!V_POL.
  - `de`=0, `line`=0, `frame`=0, `frame_cnt`=0.
  - All PIPE stages hold the inactive values.
- First rising edge after reset release gives `sx`=0, `sy`=0, `de`=1, `line`=1, `frame`=0.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). No partial sync pulse is stretched.
- `PIPE`=N delays `hsync`/`vsync`/`de` by exactly N cycles relative to `sx`/`sy`/`line`/`frame`. Coordinates and strobes are never delayed.
- Corner case at the end of the frame (sx=H_TOTAL-1 → 0 with sy=V_TOTAL-1 → 0): both counters wrap in the same cycle, and `line` fires without `frame`.
- `frame` and `line` coincide once per frame, at (0, V_RES).

## Structure
- Package `display_272p_pkg` holds:
  - the 480×272 timing constants (H/V RES, FP, SYNC, BP, POL), used as parameter defaults;
  - derived `H_TOTAL`/`V_TOTAL`;
  - a `coord_t` typedef of CORDW bits.
- One sub-module, `sig_delay`: a parameterised N-stage shift register with a reset value input, instantiated for the hsync/vsync/de bundle. N=0 is a pass-through.

## Test plan
- Reset release, PIPE=0 → first edge gives sx=0, sy=0, de=1, line=1. sx=479 has de=1; sx=480 has de=0.
- Run one line → hsync low for exactly sx 482..522 (41 cycles); sx wraps 524→0 with sy incrementing.
- Run a full frame → exactly 150150 cycles between `frame` pulses. vsync is low for sy 274..283 (10×525 cycles). frame_cnt goes 0→1 at (0,272).
- FCW=2, run 4 frames → frame_cnt goes 1,2,3,0.
- PIPE=2 → hsync/vsync/de edges lag the PIPE=0 reference by exactly 2 cycles; sx/sy/frame are unchanged.
- Assert rst_pix at (300,100) for 3 cycles → outputs take reset values asynchronously. After release, the sequence restarts at (0,0) and frame_cnt=0.
